skid_buffer_stage: RTL and testbench

//   Two-entry registered pipeline stage for valid/ready streams (skid buffer).

---
 rtl/skid_buffer_stage.sv | 62 ++++++
 tb/tb_skid_buffer_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer_stage.sv
// ============================================================================
// skid_buffer_stage: two-entry registered valid/ready stage, full throughput
// Revision: 1.0
// ============================================================================
`default_nettype none

module skid_buffer_stage #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  output logic ready_in,
  input  T     data_in,
  output logic valid_out,
  input  logic ready_out,
  output T     data_out
);

  logic main_valid;
  logic skid_valid;
  T     main_data;
  T     skid_data;

  logic acc_in;
  logic main_free;

  // ready_in comes straight from a flop, so no ready path crosses the stage
  assign ready_in  = ~skid_valid;
  assign valid_out = main_valid;
  assign data_out  = main_data;

  assign acc_in    = valid_in & ~skid_valid;
  assign main_free = ~main_valid | ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= acc_in;
        if (acc_in) begin
          main_data <= data_in;
        end
      end
    end else if (acc_in) begin
      // main is stalled: park the incoming beat so it is not lost
      skid_data  <= data_in;
      skid_valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_skid_buffer_stage.sv
// Testbench for skid_buffer_stage: a 3-stage chain against a queue model and
// scoreboard, plus a single stage for full-state and reset checks.
`timescale 1ns/1ps
`default_nettype none

module tb_skid_buffer_stage;
  typedef logic [15:0] t16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // chain
  logic src_valid, sink_ready;
  t16   src_data;
  logic rdy0, v01, r01, v12, r12, vout;
  t16   d01, d12, dout;

  // single stage
  logic s_valid, s_ready, s_ready_in, s_valid_out;
  t16   s_data, s_data_out;

  skid_buffer_stage #(.T(t16)) u_s0 (
    .clk(clk), .reset(reset), .valid_in(src_valid), .ready_in(rdy0), .data_in(src_data),
    .valid_out(v01), .ready_out(r01), .data_out(d01));
  skid_buffer_stage #(.T(t16)) u_s1 (
    .clk(clk), .reset(reset), .valid_in(v01), .ready_in(r01), .data_in(d01),
    .valid_out(v12), .ready_out(r12), .data_out(d12));
  skid_buffer_stage #(.T(t16)) u_s2 (
    .clk(clk), .reset(reset), .valid_in(v12), .ready_in(r12), .data_in(d12),
    .valid_out(vout), .ready_out(sink_ready), .data_out(dout));
  skid_buffer_stage #(.T(t16)) u_single (
    .clk(clk), .reset(reset), .valid_in(s_valid), .ready_in(s_ready_in), .data_in(s_data),
    .valid_out(s_valid_out), .ready_out(s_ready), .data_out(s_data_out));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each stage is modelled as a plain 2-deep FIFO; sb tracks end-to-end order.
  t16 q0[$], q1[$], q2[$], sb[$];
  t16 nxt;
  int remaining, vpct, rpct, stall_from, stall_len, cyc;
  int produced, consumed, first_in, first_out, low_run, max_low;
  bit saw_low;

  task automatic cycle();
    bit acc_in, mv01, mv12, acc_out;
    src_valid  = (remaining > 0) && ($urandom_range(99) < vpct);
    src_data   = nxt;
    sink_ready = ($urandom_range(99) < rpct) &&
                 !(cyc >= stall_from && cyc < stall_from + stall_len);
    @(negedge clk);
    check("ready_in", rdy0, q0.size() < 2);
    check("valid_out", vout, q2.size() > 0);
    if (q2.size() > 0) check("data_out", dout, q2[0]);
    acc_in  = src_valid && (q0.size() < 2);
    mv01    = (q0.size() > 0) && (q1.size() < 2);
    mv12    = (q1.size() > 0) && (q2.size() < 2);
    acc_out = (q2.size() > 0) && sink_ready;
    if (!rdy0) begin
      low_run++;
      saw_low = 1'b1;
      if (low_run > max_low) max_low = low_run;
    end else begin
      low_run = 0;
    end
    if (acc_out) begin
      consumed++;
      if (first_out < 0) first_out = cyc;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_order", dout, sb.pop_front());
    end
    if (acc_in) begin
      sb.push_back(src_data);
      produced++;
      if (first_in < 0) first_in = cyc;
    end
    @(posedge clk);
    if (acc_out) q2.delete(0);
    if (mv12) q2.push_back(q1.pop_front());
    if (mv01) q1.push_back(q0.pop_front());
    if (acc_in) begin
      q0.push_back(src_data);
      nxt = nxt + 16'd1;
      remaining--;
    end
    cyc++;
    #1;
  endtask

  task automatic phase(input t16 base, input int n, input int vp, input int rp,
                       input int soff, input int slen, input int max_cycles);
    nxt = base; remaining = n; vpct = vp; rpct = rp;
    stall_from = cyc + soff; stall_len = slen;
    produced = 0; consumed = 0; first_in = -1; first_out = -1;
    low_run = 0; max_low = 0; saw_low = 1'b0;
    for (int i = 0; i < max_cycles && remaining > 0; i++) cycle();
    check("src_done", remaining, 0);
    rpct = 100; stall_len = 0;
    for (int i = 0; i < 10; i++) cycle();
    check("produced", produced, n);
    check("consumed", consumed, n);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic single_check(input string tag, input bit v, input bit r, input t16 d);
    @(negedge clk);
    check({tag, "_valid"}, s_valid_out, v);
    check({tag, "_ready"}, s_ready_in, r);
    if (v) check({tag, "_data"}, s_data_out, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    src_valid = 1'b0; src_data = '0; sink_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_ready = 1'b0;
    cyc = 0; remaining = 0; vpct = 0; rpct = 100; stall_from = 0; stall_len = 0; nxt = '0;
    #1;
    check("rst_valid_out", vout, 0);
    check("rst_ready_in", rdy0, 1);
    check("rst_s_data_out", s_data_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // pass-through: 3-cycle latency, never backpressured
    phase(16'h0000, 8, 100, 100, 0, 0, 40);
    check("latency", first_out - first_in, 3);
    check("pass_ready_low", max_low, 0);

    phase(16'h0100, 10, 100, 100, 4, 1, 40);
    check("stall1_low_max", max_low <= 1, 1);

    phase(16'h0200, 16, 100, 100, 4, 5, 60);
    check("stall5_backpressure", saw_low, 1);

    phase(16'h1000, 60, 70, 50, 0, 0, 200);

    // single stage: fill main and skid, hold, then recover
    s_ready = 1'b0; s_valid = 1'b1; s_data = 16'hA1A1;
    single_check("s_empty", 0, 1, '0);
    s_data = 16'hB2B2;
    single_check("s_one", 1, 1, 16'hA1A1);
    s_data = 16'hC3C3;
    single_check("s_full0", 1, 0, 16'hA1A1);
    single_check("s_full1", 1, 0, 16'hA1A1);
    single_check("s_full2", 1, 0, 16'hA1A1);
    s_valid = 1'b0; s_ready = 1'b1;
    single_check("s_release", 1, 0, 16'hA1A1);
    s_ready = 1'b0;
    single_check("s_skid_moved", 1, 1, 16'hB2B2);
    s_ready = 1'b1;
    single_check("s_last", 1, 1, 16'hB2B2);
    single_check("s_drained", 0, 1, '0);

    // reset with two beats buffered
    s_ready = 1'b0; s_valid = 1'b1; s_data = 16'hD4D4;
    src_valid = 1'b1; src_data = 16'h5555; sink_ready = 1'b0;
    @(posedge clk); #1;
    s_data = 16'hE5E5; src_data = 16'h5556;
    @(posedge clk); #1;
    s_valid = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", s_ready_in, 0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", s_valid_out, 0);
    check("async_rst_ready", s_ready_in, 1);
    check("async_rst_chain_valid", vout, 0);
    check("async_rst_chain_ready", rdy0, 1);
    @(posedge clk); #1;
    check("rst_hold_ready", s_ready_in, 1);
    @(negedge clk);
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); sb.delete();
    @(posedge clk); #1;
    phase(16'h3000, 20, 80, 60, 0, 0, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
